// File: rtl/acc_rf_pkg.sv
// Shared types and default sizing for the accumulator register file.
package acc_rf_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } rf_state_t;

   localparam int DEF_DW      = 8;
   localparam int DEF_AW      = 4;
   localparam int DEF_ACC_IDX = 0;

endpackage

// File: rtl/rf_clear_seq.sv
// Post-reset clear sequencer: walks every entry once, then reports ready.
module rf_clear_seq
   import acc_rf_pkg::*;
#(
   parameter int AW = DEF_AW
) (
   input  logic          i_clk,
   input  logic          i_reset,
   output logic          o_clr_we,
   output logic [AW-1:0] o_clr_addr,
   output logic          o_ready
);

   rf_state_t     r_state;
   logic [AW-1:0] r_ptr;
   logic          r_ready;

   // State, clear pointer and ready flag; leaves CLEAR on the edge that zeroes the last entry
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= CLEAR;
         r_ptr   <= '0;
         r_ready <= 1'b0;
      end else if (r_state == CLEAR) begin
         r_ptr <= r_ptr + 1'b1;
         if (r_ptr == {AW{1'b1}}) begin
            r_state <= RUN;
            r_ready <= 1'b1;
         end
      end
   end

   assign o_clr_we   = (r_state == CLEAR);
   assign o_clr_addr = r_ptr;
   assign o_ready    = r_ready;

endmodule

// File: rtl/acc_reg_file.sv
// Parametrised accumulator register file with direct/accumulator addressing,
// accumulator swap, optional write-to-read bypass and a post-reset clear.
module acc_reg_file
   import acc_rf_pkg::*;
#(
   parameter int DW      = DEF_DW,
   parameter int AW      = DEF_AW,
   parameter int ACC_IDX = DEF_ACC_IDX,
   parameter int BYPASS  = 1
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_wr_en,
   input  logic          i_dir_mode,
   input  logic          i_swap_en,
   input  logic [AW-1:0] i_addrA,
   input  logic [AW-1:0] i_addrB,
   input  logic [DW-1:0] i_dat_in,
   output logic [DW-1:0] o_datA_out,
   output logic [DW-1:0] o_datB_out,
   output logic [DW-1:0] o_acc_out,
   output logic          o_ready,
   output logic          o_err
);

   localparam int          DEPTH = 1 << AW;
   localparam logic [AW-1:0] ACC  = AW'(ACC_IDX);

   logic [DW-1:0] r_core [DEPTH];
   logic          r_err;

   logic          w_clr_we;
   logic [AW-1:0] w_clr_addr;
   logic          w_ready;
   logic          w_clr;
   logic          w_swap;
   logic          w_wr;
   logic          w_bp;
   logic [AW-1:0] w_tgt;
   logic [AW-1:0] w_addrA_eff;

   rf_clear_seq #(.AW(AW)) u_clr (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .o_clr_we   (w_clr_we),
      .o_clr_addr (w_clr_addr),
      .o_ready    (w_ready)
   );

   // Operations only land once the clear has finished and reset is low;
   // a simultaneous swap wins over the write.
   assign w_clr       = w_clr_we & ~i_reset;
   assign w_swap      = w_ready & ~i_reset & i_swap_en;
   assign w_wr        = w_ready & ~i_reset & i_wr_en & ~i_swap_en;
   assign w_tgt       = i_dir_mode ? i_addrA : ACC;
   assign w_addrA_eff = w_tgt;
   assign w_bp        = (BYPASS != 0) & w_ready & i_wr_en & ~i_swap_en;

   // Storage update: clear step, swap, or plain write (mutually exclusive per edge)
   always_ff @(posedge i_clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (w_clr) begin
            if (AW'(i) == w_clr_addr) r_core[i] <= '0;
         end else if (w_swap) begin
            if (AW'(i) == ACC)          r_core[i] <= r_core[i_addrA];
            else if (AW'(i) == i_addrA) r_core[i] <= r_core[ACC];
         end else if (w_wr) begin
            if (AW'(i) == w_tgt) r_core[i] <= i_dat_in;
         end
      end
   end

   // Conflict flag: one cycle per edge that saw both swap and write in RUN
   always_ff @(posedge i_clk) begin
      if (i_reset) r_err <= 1'b0;
      else         r_err <= w_ready & i_swap_en & i_wr_en;
   end

   // Read muxes: zero while clearing, bypass in-flight write data when enabled
   always_comb begin
      o_datA_out = '0;
      o_datB_out = '0;
      o_acc_out  = '0;
      if (w_ready) begin
         o_datA_out = (w_bp && w_addrA_eff == w_tgt) ? i_dat_in : r_core[w_addrA_eff];
         o_datB_out = (w_bp && i_addrB == w_tgt)     ? i_dat_in : r_core[i_addrB];
         o_acc_out  = (w_bp && ACC == w_tgt)         ? i_dat_in : r_core[ACC];
      end
   end

   assign o_ready = w_ready;
   assign o_err   = r_err;

endmodule
